// File: rtl/cpu_control_unit.sv
// Instruction-sequencing controller for CPU_DataPath: decodes the current opcode into
// datapath strobes and sequences run/pause/step/halt/fault, one instruction per clock.
module cpu_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             C,
    input  logic             V,
    input  logic             S,
    input  logic             Z_det,
    input  logic             run,
    input  logic             step,
    output logic             ldPC2,
    output logic             ldPCz,
    output logic             ldXr1,
    output logic             ldXr2,
    output logic             ldXPC,
    output logic             ldYr1,
    output logic             ldYr2,
    output logic             alu_ld,
    output logic             ldRPC,
    output logic             ldRZ,
    output logic             ldRM,
    output logic             rdr1,
    output logic             rdr2,
    output logic             rdm,
    output logic             wrm,
    output logic             ldOff11to16,
    output logic             ldOff8to16,
    output logic             ldOff5to16,
    output logic [2:0]       fsel,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADDR = 5'b00001;
    localparam logic [4:0] OP_SUBR = 5'b00010;
    localparam logic [4:0] OP_ANDR = 5'b00011;
    localparam logic [4:0] OP_ORR  = 5'b00100;
    localparam logic [4:0] OP_XORR = 5'b00101;
    localparam logic [4:0] OP_LI   = 5'b01100;
    localparam logic [4:0] OP_LR   = 5'b01101;
    localparam logic [4:0] OP_SW   = 5'b10000;
    localparam logic [4:0] OP_LA   = 5'b10001;
    localparam logic [4:0] OP_JAL  = 5'b11000;
    localparam logic [4:0] OP_JR   = 5'b11010;
    localparam logic [4:0] OP_BEQZ = 5'b11100;
    localparam logic [4:0] OP_BNEZ = 5'b11101;
    localparam logic [4:0] OP_BLTZ = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam int B_PC2   = 17;
    localparam int B_PCZ   = 16;
    localparam int B_XR1   = 15;
    localparam int B_XR2   = 14;
    localparam int B_XPC   = 13;
    localparam int B_YR2   = 11;
    localparam int B_ALU   = 10;
    localparam int B_RPC   = 9;
    localparam int B_RZ    = 8;
    localparam int B_RM    = 7;
    localparam int B_RD1   = 6;
    localparam int B_RD2   = 5;
    localparam int B_RDM   = 4;
    localparam int B_WRM   = 3;
    localparam int B_OFF11 = 2;
    localparam int B_OFF8  = 1;
    localparam int B_OFF5  = 0;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        step_d;
    logic        cq, vq, sq, zq;
    logic        exec;
    logic        step_edge;
    logic        is_legal;
    logic        is_halt;
    logic        is_alu;
    logic        taken;
    logic [17:0] dec;
    logic [2:0]  dec_fsel;
    logic        flags_unused;

    // C and V are held for the datapath's benefit; no branch here reads them.
    assign flags_unused = ^{cq, vq};

    assign exec      = (state == ST_RUN) || (state == ST_STEP);
    assign step_edge = step && !step_d;

    always_comb begin
        dec      = '0;
        dec_fsel = 3'd0;
        is_legal = 1'b1;
        is_halt  = 1'b0;
        is_alu   = 1'b0;
        taken    = 1'b0;
        case (opcode)
            OP_NOP: dec[B_PC2] = 1'b1;
            OP_ADDR, OP_SUBR, OP_ANDR, OP_ORR, OP_XORR: begin
                is_alu     = 1'b1;
                dec[B_PC2] = 1'b1;
                dec[B_XR1] = 1'b1;
                dec[B_YR2] = 1'b1;
                dec[B_RD1] = 1'b1;
                dec[B_RD2] = 1'b1;
                dec[B_ALU] = 1'b1;
                dec[B_RZ]  = 1'b1;
                dec_fsel   = opcode[2:0] - 3'd1;
            end
            OP_LI: begin
                dec[B_PC2]  = 1'b1;
                dec[B_OFF8] = 1'b1;
                dec[B_ALU]  = 1'b1;
                dec[B_RZ]   = 1'b1;
                dec_fsel    = 3'd7;
            end
            OP_LR: begin
                dec[B_PC2] = 1'b1;
                dec[B_XR2] = 1'b1;
                dec[B_RD2] = 1'b1;
                dec[B_ALU] = 1'b1;
                dec[B_RZ]  = 1'b1;
                dec_fsel   = 3'd6;
            end
            OP_SW: begin
                dec[B_PC2]  = 1'b1;
                dec[B_XR2]  = 1'b1;
                dec[B_OFF5] = 1'b1;
                dec[B_RD1]  = 1'b1;
                dec[B_RD2]  = 1'b1;
                dec[B_ALU]  = 1'b1;
                dec[B_WRM]  = 1'b1;
            end
            OP_LA: begin
                dec[B_PC2]  = 1'b1;
                dec[B_XR2]  = 1'b1;
                dec[B_OFF5] = 1'b1;
                dec[B_RD2]  = 1'b1;
                dec[B_ALU]  = 1'b1;
                dec[B_RDM]  = 1'b1;
                dec[B_RM]   = 1'b1;
            end
            OP_JAL: begin
                dec[B_PCZ]  = 1'b1;
                dec[B_XPC]  = 1'b1;
                dec[B_OFF8] = 1'b1;
                dec[B_ALU]  = 1'b1;
                dec[B_RPC]  = 1'b1;
            end
            OP_JR: begin
                dec[B_PCZ] = 1'b1;
                dec[B_XR1] = 1'b1;
                dec[B_RD1] = 1'b1;
                dec[B_ALU] = 1'b1;
                dec_fsel   = 3'd6;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ: begin
                // Branches test the registered flags of the last ALU register op.
                if (opcode == OP_BEQZ)      taken = zq;
                else if (opcode == OP_BNEZ) taken = !zq;
                else                        taken = sq;
                if (taken) begin
                    dec[B_PCZ]   = 1'b1;
                    dec[B_XPC]   = 1'b1;
                    dec[B_OFF11] = 1'b1;
                    dec[B_ALU]   = 1'b1;
                end else begin
                    dec[B_PC2] = 1'b1;
                end
            end
            OP_HALT: is_halt = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    assign {ldPC2, ldPCz, ldXr1, ldXr2, ldXPC, ldYr1, ldYr2, alu_ld, ldRPC, ldRZ, ldRM,
            rdr1, rdr2, rdm, wrm, ldOff11to16, ldOff8to16, ldOff5to16} = exec ? dec : 18'd0;
    assign fsel = exec ? dec_fsel : 3'd0;

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = run ? ST_RUN : ST_PAUSE;
            ST_RUN, ST_STEP: begin
                if (is_halt)                        state_next = ST_HALT;
                else if (!is_legal)                 state_next = ST_FAULT;
                else if (state == ST_STEP || !run)  state_next = ST_PAUSE;
                else                                state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (step_edge) state_next = ST_STEP;
                else if (run)  state_next = ST_RUN;
            end
            ST_HALT:  state_next = ST_HALT;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            step_d      <= 1'b0;
            cq          <= 1'b0;
            vq          <= 1'b0;
            sq          <= 1'b0;
            zq          <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= state_next;
            step_d <= step;
            halted <= (state_next == ST_HALT);
            fault  <= (state_next == ST_FAULT);
            if (exec && is_alu) begin
                cq <= C;
                vq <= V;
                sq <= S;
                zq <= Z_det;
            end
            if (exec && is_legal && !is_halt)
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: decode table vectors, hand-written sequences and random
// stimulus checked against a cycle-level behavioural model of the controller.
module tb_cpu_control_unit;

    localparam logic [20:0] S_PC2   = 21'd1 << 20;
    localparam logic [20:0] S_PCZ   = 21'd1 << 19;
    localparam logic [20:0] S_XR1   = 21'd1 << 18;
    localparam logic [20:0] S_XR2   = 21'd1 << 17;
    localparam logic [20:0] S_XPC   = 21'd1 << 16;
    localparam logic [20:0] S_YR2   = 21'd1 << 14;
    localparam logic [20:0] S_ALU   = 21'd1 << 13;
    localparam logic [20:0] S_RPC   = 21'd1 << 12;
    localparam logic [20:0] S_RZ    = 21'd1 << 11;
    localparam logic [20:0] S_RM    = 21'd1 << 10;
    localparam logic [20:0] S_RD1   = 21'd1 << 9;
    localparam logic [20:0] S_RD2   = 21'd1 << 8;
    localparam logic [20:0] S_RDM   = 21'd1 << 7;
    localparam logic [20:0] S_WRM   = 21'd1 << 6;
    localparam logic [20:0] S_OFF11 = 21'd1 << 5;
    localparam logic [20:0] S_OFF8  = 21'd1 << 4;
    localparam logic [20:0] S_OFF5  = 21'd1 << 3;
    localparam logic [20:0] S_ALUR  = S_PC2 | S_XR1 | S_YR2 | S_RD1 | S_RD2 | S_ALU | S_RZ;

    localparam int M_BOOT = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3, M_HALT = 4, M_FAULT = 5;

    typedef struct {
        logic [4:0]  op;
        logic [20:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  opcode = 5'd0;
    logic        c_in = 1'b0, v_in = 1'b0, s_in = 1'b0, z_in = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;

    logic [20:0] v1, v4;
    logic        h1, f1, h4, f4;
    logic [15:0] cnt1;
    logic [3:0]  cnt4;

    int total = 0;
    int bad = 0;

    // behavioural model state
    int          mode;
    logic        mz, ms, mstep_d;
    logic [15:0] mcount;
    int          exec_ops[15] = '{0, 1, 2, 3, 4, 5, 12, 13, 16, 17, 24, 26, 28, 29, 30};

    // values captured at the last sample point
    logic [20:0] act_vec;
    logic        act_halted, act_fault;
    logic [15:0] act_cnt;
    logic [3:0]  act_cnt4;

    always #5 clk = ~clk;

    cpu_control_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .C(c_in), .V(v_in), .S(s_in), .Z_det(z_in),
        .run(run), .step(step),
        .ldPC2(v1[20]), .ldPCz(v1[19]), .ldXr1(v1[18]), .ldXr2(v1[17]), .ldXPC(v1[16]),
        .ldYr1(v1[15]), .ldYr2(v1[14]), .alu_ld(v1[13]), .ldRPC(v1[12]), .ldRZ(v1[11]),
        .ldRM(v1[10]), .rdr1(v1[9]), .rdr2(v1[8]), .rdm(v1[7]), .wrm(v1[6]),
        .ldOff11to16(v1[5]), .ldOff8to16(v1[4]), .ldOff5to16(v1[3]), .fsel(v1[2:0]),
        .halted(h1), .fault(f1), .instr_count(cnt1)
    );

    cpu_control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .C(c_in), .V(v_in), .S(s_in), .Z_det(z_in),
        .run(run), .step(step),
        .ldPC2(v4[20]), .ldPCz(v4[19]), .ldXr1(v4[18]), .ldXr2(v4[17]), .ldXPC(v4[16]),
        .ldYr1(v4[15]), .ldYr2(v4[14]), .alu_ld(v4[13]), .ldRPC(v4[12]), .ldRZ(v4[11]),
        .ldRM(v4[10]), .rdr1(v4[9]), .rdr2(v4[8]), .rdm(v4[7]), .wrm(v4[6]),
        .ldOff11to16(v4[5]), .ldOff8to16(v4[4]), .ldOff5to16(v4[3]), .fsel(v4[2:0]),
        .halted(h4), .fault(f4), .instr_count(cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic is_exec_op(input logic [4:0] op);
        foreach (exec_ops[i]) if (int'(op) == exec_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [20:0] model_decode(input logic [4:0] op, input logic z, input logic s);
        case (int'(op))
            0:             return S_PC2;
            1, 2, 3, 4, 5: return S_ALUR | 21'(int'(op) - 1);
            12:            return S_PC2 | S_OFF8 | S_ALU | S_RZ | 21'd7;
            13:            return S_PC2 | S_XR2 | S_RD2 | S_ALU | S_RZ | 21'd6;
            16:            return S_PC2 | S_XR2 | S_OFF5 | S_RD1 | S_RD2 | S_ALU | S_WRM;
            17:            return S_PC2 | S_XR2 | S_OFF5 | S_RD2 | S_ALU | S_RDM | S_RM;
            24:            return S_PCZ | S_XPC | S_OFF8 | S_ALU | S_RPC;
            26:            return S_PCZ | S_XR1 | S_RD1 | S_ALU | 21'd6;
            28, 29, 30: begin
                logic tk;
                tk = (op == 5'd28) ? z : (op == 5'd29) ? !z : s;
                return tk ? (S_PCZ | S_XPC | S_OFF11 | S_ALU) : S_PC2;
            end
            default:       return 21'd0;
        endcase
    endfunction

    task automatic model_reset();
        mode    = M_BOOT;
        mz      = 1'b0;
        ms      = 1'b0;
        mstep_d = 1'b0;
        mcount  = 16'd0;
    endtask

    task automatic model_update();
        case (mode)
            M_BOOT:  mode = run ? M_RUN : M_PAUSE;
            M_RUN, M_STEP: begin
                if (opcode == 5'd31) mode = M_HALT;
                else if (!is_exec_op(opcode)) mode = M_FAULT;
                else begin
                    mcount = mcount + 16'd1;
                    if (opcode >= 5'd1 && opcode <= 5'd5) begin
                        mz = z_in;
                        ms = s_in;
                    end
                    mode = (mode == M_RUN && run) ? M_RUN : M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (step && !mstep_d) mode = M_STEP;
                else if (run)         mode = M_RUN;
            end
            default: ;
        endcase
        mstep_d = step;
    endtask

    task automatic check_now(input string tag);
        logic [20:0] exp_vec;
        exp_vec    = (mode == M_RUN || mode == M_STEP) ? model_decode(opcode, mz, ms) : 21'd0;
        act_vec    = v1;
        act_halted = h1;
        act_fault  = f1;
        act_cnt    = cnt1;
        act_cnt4   = cnt4;
        check({tag, "_strobes"}, 64'(v1), 64'(exp_vec));
        check({tag, "_status"}, 64'({h1, f1, cnt1}), 64'({mode == M_HALT, mode == M_FAULT, mcount}));
        check({tag, "_w4"}, 64'({v4, h4, f4, cnt4}),
              64'({exp_vec, mode == M_HALT, mode == M_FAULT, mcount[3:0]}));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_cycle(input logic [4:0] op, input logic r, input logic s,
                            input logic [3:0] flags, input string tag);
        opcode = op;
        run    = r;
        step   = s;
        {c_in, v_in, s_in, z_in} = flags;
        #1 check_now(tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        #1 check_now("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{5'd0,  S_PC2};
        tbl[1]  = '{5'd1,  S_ALUR | 21'd0};
        tbl[2]  = '{5'd2,  S_ALUR | 21'd1};
        tbl[3]  = '{5'd3,  S_ALUR | 21'd2};
        tbl[4]  = '{5'd4,  S_ALUR | 21'd3};
        tbl[5]  = '{5'd5,  S_ALUR | 21'd4};
        tbl[6]  = '{5'd12, S_PC2 | S_OFF8 | S_ALU | S_RZ | 21'd7};
        tbl[7]  = '{5'd13, S_PC2 | S_XR2 | S_RD2 | S_ALU | S_RZ | 21'd6};
        tbl[8]  = '{5'd16, S_PC2 | S_XR2 | S_OFF5 | S_RD1 | S_RD2 | S_ALU | S_WRM};
        tbl[9]  = '{5'd17, S_PC2 | S_XR2 | S_OFF5 | S_RD2 | S_ALU | S_RDM | S_RM};
        tbl[10] = '{5'd24, S_PCZ | S_XPC | S_OFF8 | S_ALU | S_RPC};
        tbl[11] = '{5'd26, S_PCZ | S_XR1 | S_RD1 | S_ALU | 21'd6};
        tbl[12] = '{5'd28, S_PC2};                                   // Zq=0: not taken
        tbl[13] = '{5'd29, S_PCZ | S_XPC | S_OFF11 | S_ALU};         // Zq=0: taken
        tbl[14] = '{5'd30, S_PC2};                                   // Sq=0: not taken

        model_reset();
        @(negedge clk);
        reset_dut();

        // decode table, flags kept at zero
        do_cycle(5'd0, 1'b1, 1'b0, 4'h0, "boot");
        for (int i = 0; i < 15; i++) begin
            do_cycle(tbl[i].op, 1'b1, 1'b0, 4'h0, "tbl");
            check($sformatf("tbl_op%0d", tbl[i].op), 64'(act_vec), 64'(tbl[i].exp));
        end

        // li, lr, addr, halt: halted visible in cycle 6 after reset
        reset_dut();
        do_cycle(5'd0,  1'b1, 1'b0, 4'h0, "prog");
        do_cycle(5'd12, 1'b1, 1'b0, 4'h0, "prog");
        do_cycle(5'd13, 1'b1, 1'b0, 4'h0, "prog");
        do_cycle(5'd1,  1'b1, 1'b0, 4'h0, "prog");
        do_cycle(5'd31, 1'b1, 1'b0, 4'h0, "prog");
        check("prog_halt_strobes", 64'(act_vec), 64'd0);
        do_cycle(5'd0,  1'b1, 1'b1, 4'h0, "prog");
        check("prog_halted", 64'(act_halted), 64'd1);
        check("prog_count", 64'(act_cnt), 64'd3);

        // subr result zero then beqz taken; nonzero then not taken
        reset_dut();
        do_cycle(5'd0,  1'b1, 1'b0, 4'h0, "br");
        do_cycle(5'd2,  1'b1, 1'b0, 4'h1, "br");
        do_cycle(5'd28, 1'b1, 1'b0, 4'h0, "br");
        check("beqz_taken", 64'(act_vec), 64'(S_PCZ | S_XPC | S_OFF11 | S_ALU));
        do_cycle(5'd2,  1'b1, 1'b0, 4'h0, "br");
        do_cycle(5'd28, 1'b1, 1'b0, 4'h0, "br");
        check("beqz_not_taken", 64'(act_vec), 64'(S_PC2));
        do_cycle(5'd0,  1'b0, 1'b0, 4'h0, "br");
        check("br_count", 64'(act_cnt), 64'd4);

        // paused start, three step pulses, then step held high
        reset_dut();
        do_cycle(5'd12, 1'b0, 1'b0, 4'h0, "stp");
        for (int i = 0; i < 3; i++) begin
            do_cycle(5'd12, 1'b0, 1'b1, 4'h0, "stp");
            check("pause_quiet", 64'(act_vec), 64'd0);
            do_cycle(5'd12, 1'b0, 1'b0, 4'h0, "stp");
        end
        do_cycle(5'd12, 1'b0, 1'b0, 4'h0, "stp");
        check("step_count3", 64'(act_cnt), 64'd3);
        for (int i = 0; i < 5; i++) do_cycle(5'd12, 1'b0, 1'b1, 4'h0, "stp");
        do_cycle(5'd12, 1'b0, 1'b0, 4'h0, "stp");
        check("step_held_count", 64'(act_cnt), 64'd4);

        // illegal opcode traps and stays trapped
        reset_dut();
        do_cycle(5'd0,  1'b1, 1'b0, 4'h0, "ill");
        do_cycle(5'd12, 1'b1, 1'b0, 4'h0, "ill");
        do_cycle(5'd7,  1'b1, 1'b0, 4'h0, "ill");
        check("illegal_strobes", 64'(act_vec), 64'd0);
        do_cycle(5'd12, 1'b1, 1'b0, 4'h0, "ill");
        check("fault_next", 64'(act_fault), 64'd1);
        for (int i = 0; i < 6; i++) do_cycle(5'd12, i[0], i[1], 4'h0, "ill");
        check("fault_sticky", 64'({act_fault, act_vec, act_cnt}), 64'({1'b1, 21'd0, 16'd1}));

        // reset in the middle of a store cycle
        reset_dut();
        do_cycle(5'd0,  1'b1, 1'b0, 4'h0, "sw");
        do_cycle(5'd12, 1'b1, 1'b0, 4'h0, "sw");
        opcode = 5'd16;
        #1 check("sw_wrm_before", 64'(v1[6]), 64'd1);
        #1 rst = 1'b1;
        model_reset();
        #1 check("sw_rst_outputs", 64'({v1, h1, f1, cnt1}), 64'd0);
        check_now("sw_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 17 nops on the 4-bit counter wrap to 1
        do_cycle(5'd0, 1'b1, 1'b0, 4'h0, "wrap");
        for (int i = 0; i < 17; i++) do_cycle(5'd0, 1'b1, 1'b0, 4'h0, "wrap");
        do_cycle(5'd31, 1'b1, 1'b0, 4'h0, "wrap");
        check("wrap_cnt4", 64'(act_cnt4), 64'd1);
        check("wrap_cnt16", 64'(act_cnt), 64'd17);

        // random stimulus against the model
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            if (mode == M_HALT || mode == M_FAULT || $urandom_range(0, 99) == 0) begin
                reset_dut();
            end else begin
                logic [4:0] op;
                int n;
                n = $urandom_range(0, 99);
                if (n < 94)      op = 5'(exec_ops[$urandom_range(0, 14)]);
                else if (n < 97) op = 5'd31;
                else begin
                    op = 5'($urandom_range(0, 30));
                    while (is_exec_op(op)) op = 5'($urandom_range(6, 30));
                end
                do_cycle(op, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
